// File: rtl/config_handshake_fsm_pkg.sv
// Shared constants and types for the UART link configuration handshake.
package config_handshake_fsm_pkg;

    localparam logic [7:0] SYN_BYTE  = 8'hF1;
    localparam logic [7:0] ACK_BYTE  = 8'hA5;
    localparam logic [7:0] NACK_BYTE = 8'h5A;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_SYN   = 3'd1,
        TX_CFG   = 3'd2,
        WAIT_ACK = 3'd3,
        RX_CFG   = 3'd4,
        TX_RESP  = 3'd5,
        FINISH   = 3'd6
    } cfg_hs_state_t;

    typedef struct packed {
        logic [1:0] data_width;
        logic [1:0] parity_mode;
        logic [1:0] stop_bits;
    } uart_cfg_t;

    // Configuration byte on the wire: two reserved zero bits above the fields.
    function automatic logic [7:0] cfg_to_byte(input uart_cfg_t cfg);
        return {2'b00, cfg};
    endfunction

endpackage

// File: rtl/config_handshake_fsm_timeout.sv
// Remote-byte timeout counter: counts while enabled, flags the last cycle of the window.
module config_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at the last value so expiry stays visible until the FSM reacts.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (enable_i && (r_count != CNT_LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired_o = enable_i && (r_count == CNT_LAST);

endmodule

// File: rtl/config_handshake_fsm.sv
// Link-level configuration exchange sequencer (initiator and responder roles).
module config_handshake_fsm
    import config_handshake_fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       send_config_req_i,
    input  logic       enable_config_i,
    input  logic       ack_request_i,
    input  logic [1:0] updated_data_width_i,
    input  logic [1:0] updated_parity_mode_i,
    input  logic [1:0] updated_stop_bits_i,
    input  logic       tx_idle_i,
    input  logic       tx_done_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_req_o,
    output logic       STR_en_o,
    output logic [1:0] data_width_o,
    output logic [1:0] parity_mode_o,
    output logic [1:0] stop_bits_o,
    output logic       config_done_o,
    output logic       set_std_config_o,
    output logic       config_error_o,
    output logic       busy_o
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

    cfg_hs_state_t      r_state;
    cfg_hs_state_t      w_next_state;
    logic               r_pending;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic               r_sent;
    logic               r_fail;
    logic [7:0]         r_resp_byte;

    logic               w_timer_en;
    logic               w_expired;
    logic               w_in_tx;
    logic               w_tx_fire;
    logic               w_tx_complete;
    logic               w_rx_syn;
    logic               w_rx_accept;
    logic               w_leave_idle;
    logic [7:0]         w_tx_byte;
    uart_cfg_t          w_local_cfg;

    assign w_local_cfg   = {updated_data_width_i, updated_parity_mode_i, updated_stop_bits_i};
    assign w_timer_en    = (r_state == WAIT_ACK) || (r_state == RX_CFG);
    assign w_in_tx       = (r_state == TX_SYN) || (r_state == TX_CFG) || (r_state == TX_RESP);
    assign w_tx_fire     = w_in_tx && !r_sent && tx_idle_i;
    assign w_tx_complete = w_in_tx && r_sent && tx_done_i;
    assign w_rx_syn      = rx_valid_i && (rx_data_i == SYN_BYTE);
    assign w_rx_accept   = enable_config_i && (rx_data_i[7:6] == 2'b00);
    assign w_leave_idle  = (r_state == IDLE) && (w_next_state != IDLE);

    config_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (!w_timer_en),
        .enable_i (w_timer_en),
        .expired_o(w_expired)
    );

    always_comb begin
        w_tx_byte = SYN_BYTE;
        case (r_state)
            TX_CFG:  w_tx_byte = cfg_to_byte(w_local_cfg);
            TX_RESP: w_tx_byte = r_resp_byte;
            default: w_tx_byte = SYN_BYTE;
        endcase
    end

    // Next-state decision; a remote SYN in IDLE takes priority over a local request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_rx_syn) begin
                    w_next_state = RX_CFG;
                end else if (r_pending || send_config_req_i) begin
                    w_next_state = TX_SYN;
                end
            end
            TX_SYN: begin
                if (w_tx_complete) w_next_state = TX_CFG;
            end
            TX_CFG: begin
                if (w_tx_complete) w_next_state = ack_request_i ? WAIT_ACK : FINISH;
            end
            WAIT_ACK: begin
                if (rx_valid_i && ((rx_data_i == ACK_BYTE) || (rx_data_i == NACK_BYTE))) begin
                    w_next_state = FINISH;
                end else if (w_expired) begin
                    w_next_state = (r_retry_cnt < RETRY_LAST) ? TX_SYN : FINISH;
                end
            end
            RX_CFG: begin
                if (rx_valid_i) begin
                    w_next_state = TX_RESP;
                end else if (w_expired) begin
                    w_next_state = IDLE;
                end
            end
            TX_RESP: begin
                if (w_tx_complete) w_next_state = FINISH;
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state          <= IDLE;
            r_pending        <= 1'b0;
            r_retry_cnt      <= '0;
            r_sent           <= 1'b0;
            r_fail           <= 1'b0;
            r_resp_byte      <= 8'h00;
            tx_data_o        <= 8'h00;
            tx_req_o         <= 1'b0;
            STR_en_o         <= 1'b0;
            data_width_o     <= 2'b00;
            parity_mode_o    <= 2'b00;
            stop_bits_o      <= 2'b00;
            config_done_o    <= 1'b1;
            set_std_config_o <= 1'b0;
            config_error_o   <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            tx_req_o         <= 1'b0;
            STR_en_o         <= 1'b0;
            set_std_config_o <= 1'b0;
            busy_o           <= (w_next_state != IDLE);
            config_done_o    <= (w_next_state == IDLE);

            if ((r_state == IDLE) && (w_next_state == TX_SYN)) begin
                r_pending <= 1'b0;
            end else if (send_config_req_i) begin
                r_pending <= 1'b1;
            end

            if (w_leave_idle) begin
                r_retry_cnt    <= '0;
                r_fail         <= 1'b0;
                config_error_o <= 1'b0;
            end

            // One request per byte; wait for tx_done before moving on.
            if (w_tx_fire) begin
                tx_req_o  <= 1'b1;
                tx_data_o <= w_tx_byte;
                r_sent    <= 1'b1;
            end else if (w_tx_complete) begin
                r_sent    <= 1'b0;
            end

            if (r_state == WAIT_ACK) begin
                if (w_next_state == TX_SYN) begin
                    r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                end else if (w_next_state == FINISH) begin
                    r_fail <= !(rx_valid_i && (rx_data_i == ACK_BYTE));
                end
            end

            if ((r_state == RX_CFG) && rx_valid_i) begin
                if (w_rx_accept) begin
                    STR_en_o      <= 1'b1;
                    data_width_o  <= rx_data_i[5:4];
                    parity_mode_o <= rx_data_i[3:2];
                    stop_bits_o   <= rx_data_i[1:0];
                    r_resp_byte   <= ACK_BYTE;
                end else begin
                    r_resp_byte   <= NACK_BYTE;
                end
            end

            if (r_state == FINISH) begin
                config_error_o   <= r_fail;
                set_std_config_o <= r_fail;
            end
        end
    end

endmodule
